param_universal_register: RTL and testbench

- Parametrised successor to the team's single-bit synchronous D flip-flop: a WIDTH-bit register with hold, parallel load, shift, rotate and up/down count modes.
- Adds an enable, a synchronous clear, serial I/O, a carry/shift-out flag and a zero flag.
- Used as the general-purpose storage/shift/count element in later lab datapaths.
- Reset semantics change relative to the earlier flip-flop: reset is asynchronous and active-low.

---
 rtl/param_universal_register_if.sv | 27 ++
 rtl/param_universal_register.sv | 81 ++++++++
 tb/tb_param_universal_register.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/param_universal_register_if.sv
// Bus bundle for the universal register: control, data and serial inputs
// driven by the master, register state and flags returned by the slave.
interface param_universal_register_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             sclr;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             co;
  logic             zero;

  modport master (
    output en, sclr, mode, d, sin_l, sin_r,
    input  q, sout_l, sout_r, co, zero
  );

  modport slave (
    input  en, sclr, mode, d, sin_l, sin_r,
    output q, sout_l, sout_r, co, zero
  );
endinterface

// File: rtl/param_universal_register.sv
// WIDTH-bit register with hold, load, shift, rotate and up/down count modes,
// synchronous clear, serial I/O, a single-cycle carry/shift-out flag and a zero flag.
module param_universal_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  param_universal_register_if.slave   bus
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_UP   = 3'b110;
  localparam logic [2:0] MODE_DOWN = 3'b111;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;

  // Clear beats enable; co defaults low so it only pulses for one cycle.
  always_comb begin
    q_d  = q_q;
    co_d = 1'b0;
    if (bus.sclr) begin
      q_d = '0;
    end else if (bus.en) begin
      case (bus.mode)
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = bus.d;
        MODE_SHL: begin
          q_d  = {q_q[WIDTH-2:0], bus.sin_r};
          co_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d  = {bus.sin_l, q_q[WIDTH-1:1]};
          co_d = q_q[0];
        end
        MODE_ROL: begin
          q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          co_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d  = {q_q[0], q_q[WIDTH-1:1]};
          co_d = q_q[0];
        end
        MODE_UP: begin
          q_d  = q_q + ONE;
          co_d = &q_q;
        end
        MODE_DOWN: begin
          q_d  = q_q - ONE;
          co_d = ~|q_q;
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q  <= RESET_VALUE;
      co_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      co_q <= co_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.co     = co_q;
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.sout_r = q_q[0];
  assign bus.zero   = (q_q == '0);

endmodule

// File: tb/tb_param_universal_register.sv
// Randomised scoreboard bench for param_universal_register (WIDTH=8, RESET_VALUE=8'hA5):
// stimulus pushes arithmetic-model predictions, a monitor pops and compares.
module tb_param_universal_register;

  localparam logic [7:0] RV = 8'hA5;

  typedef struct {
    logic [7:0] q;
    logic       co;
    int         id;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  param_universal_register_if #(.WIDTH(8)) bus();

  param_universal_register #(.WIDTH(8), .RESET_VALUE(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t exp_q[$];
  event async_ev;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   txn_id    = 0;
  int   m_q       = RV;
  int   m_co      = 0;

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s txn=%0d actual=%h required=%h", name, id, act, req);
  endtask

  // Reference model: register value as an integer 0..255, modes as plain arithmetic.
  task automatic model_step(input bit en, input bit sclr, input bit [2:0] mode,
                            input bit [7:0] d, input bit sl, input bit sr);
    int v;
    v = m_q;
    m_co = 0;
    if (sclr) m_q = 0;
    else if (en) begin
      case (mode)
        3'd0: m_q = v;
        3'd1: m_q = int'(d);
        3'd2: begin m_co = (v >= 128); m_q = (v * 2 + int'(sr)) % 256; end
        3'd3: begin m_co = v % 2; m_q = v / 2 + int'(sl) * 128; end
        3'd4: begin m_co = (v >= 128); m_q = (v * 2 + v / 128) % 256; end
        3'd5: begin m_co = v % 2; m_q = v / 2 + (v % 2) * 128; end
        3'd6: begin m_co = (v == 255); m_q = (v + 1) % 256; end
        default: begin m_co = (v == 0); m_q = (v + 255) % 256; end
      endcase
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.q  = 8'(m_q);
    e.co = 1'(m_co);
    e.id = txn_id++;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit en, input bit sclr, input bit [2:0] mode,
                     input bit [7:0] d, input bit sl, input bit sr);
    @(negedge clk);
    reset     = 1'b1;
    bus.en    = en;
    bus.sclr  = sclr;
    bus.mode  = mode;
    bus.d     = d;
    bus.sin_l = sl;
    bus.sin_r = sr;
    model_step(en, sclr, mode, d, sl, sr);
    push_exp();
  endtask

  // Reset mid-cycle: check immediately, then check again across an edge held in reset.
  task automatic do_reset();
    @(negedge clk);
    #2;
    bus.en   = 1'b1;
    bus.sclr = 1'($urandom_range(0, 1));
    bus.mode = 3'($urandom);
    bus.d    = 8'($urandom);
    reset    = 1'b0;
    m_q  = RV;
    m_co = 0;
    push_exp();
    push_exp();
    -> async_ev;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q", e.id, bus.q, e.q);
        chk("co", e.id, 8'(bus.co), 8'(e.co));
        chk("sout_l", e.id, 8'(bus.sout_l), 8'(e.q[7]));
        chk("sout_r", e.id, 8'(bus.sout_r), 8'(e.q[0]));
        chk("zero", e.id, 8'(bus.zero), 8'(e.q == 8'h00));
        $display("txn %0d: q=%h co=%b zero=%b (expected q=%h co=%b)",
                 e.id, bus.q, bus.co, bus.zero, e.q, e.co);
      end
    end
  end

  initial begin : stimulus
    int w;
    reset = 1'b0;
    bus.en = 1'b0; bus.sclr = 1'b0; bus.mode = 3'd0; bus.d = 8'h00;
    bus.sin_l = 1'b0; bus.sin_r = 1'b0;
    repeat (2) @(negedge clk);
    push_exp();
    -> async_ev;

    // Directed sequence
    cyc(1, 0, 3'd1, 8'h3C, 0, 0);
    do_reset();
    cyc(0, 0, 3'd1, 8'h11, 0, 0);
    cyc(0, 0, 3'd6, 8'h22, 0, 0);
    cyc(1, 0, 3'd1, 8'h81, 0, 0);
    cyc(1, 0, 3'd2, 8'h00, 0, 1);
    cyc(1, 0, 3'd3, 8'h00, 0, 0);
    cyc(1, 0, 3'd1, 8'h80, 0, 0);
    cyc(1, 0, 3'd4, 8'h00, 1, 1);
    cyc(1, 0, 3'd5, 8'h00, 0, 0);
    cyc(0, 0, 3'd5, 8'h00, 0, 0);
    cyc(1, 0, 3'd1, 8'hFE, 0, 0);
    repeat (3) cyc(1, 0, 3'd6, 8'h00, 0, 0);
    cyc(1, 0, 3'd1, 8'h01, 0, 0);
    repeat (2) cyc(1, 0, 3'd7, 8'h00, 0, 0);
    cyc(0, 1, 3'd1, 8'h77, 0, 0);
    cyc(1, 1, 3'd1, 8'h55, 0, 0);
    do_reset();
    cyc(1, 0, 3'd7, 8'h00, 0, 0);

    // Randomised operation with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      else cyc(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 6),
               3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    cyc(0, 0, 3'd0, 8'h00, 0, 0);

    w = 0;
    while (exp_q.size() > 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
